// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared ring-router types plus output-arbiter state and round-robin helper.
package noc;

  typedef enum logic [1:0] {
    kWestPort  = 2'd0,
    kEastPort  = 2'd1,
    kLocalPort = 2'd2
  } noc_port_t;

  typedef struct packed {
    logic head;
    logic tail;
  } preamble_t;

  typedef enum logic {
    kFlowControlCreditBased,
    kFlowControlAckNack
  } noc_flow_control_t;

  localparam logic [2:0] AllPorts = 3'b111;

  typedef enum logic {
    kArbIdle,
    kArbLocked
  } arb_state_t;

  function automatic noc_port_t rr_next(input noc_port_t idx, input int n);
    if (int'(idx) + 1 >= n) return kWestPort;
    return noc_port_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// rtl/noc_rr_pick.sv - combinational round-robin picker: first request at or after prio, wrapping.
module noc_rr_pick
  import noc::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  noc_port_t    prio,
  output logic [N-1:0] win,
  output noc_port_t    win_idx,
  output logic         any
);

  int j;

  always_comb begin
    win     = '0;
    win_idx = kWestPort;
    any     = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(prio) + k;
      if (j >= N) j = j - N;
      if (!any && req[j[1:0]]) begin
        any           = 1'b1;
        win[j[1:0]]   = 1'b1;
        win_idx       = noc_port_t'(j[1:0]);
      end
    end
  end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - per-output wormhole arbiter with round-robin priority and credit/ready gating.
module noc_output_arbiter
  import noc::*;
#(
  parameter int                     NumInputs   = 3,
  parameter logic [NumInputs-1:0]   PortsEnable = AllPorts,
  parameter noc_flow_control_t      FlowControl = kFlowControlCreditBased,
  parameter int                     CreditDepth = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumInputs-1:0]               request,
  input  logic [NumInputs*2-1:0]             preamble,
  input  logic                               credit_in,
  input  logic                               ready_in,
  output logic [NumInputs-1:0]               grant,
  output logic                               out_valid,
  output logic                               locked,
  output logic [1:0]                         owner,
  output logic [$clog2(CreditDepth+1)-1:0]   credits,
  output logic                               proto_err
);

  localparam int             CW          = $clog2(CreditDepth + 1);
  localparam logic [CW-1:0]  FullCredits = CW'(CreditDepth);
  localparam logic [CW-1:0]  OneCredit   = CW'(1);

  arb_state_t          state_q, state_d;
  noc_port_t           prio_q, prio_d;
  noc_port_t           owner_q, owner_d;
  logic [CW-1:0]       credits_q, credits_d;
  logic                err_q, err_d;

  logic [NumInputs-1:0] eff_req, head_vec, tail_vec, cand, win;
  noc_port_t            win_idx;
  logic                 win_any, can_send;
  preamble_t            pre_i;

  always_comb begin
    head_vec = '0;
    tail_vec = '0;
    pre_i    = '0;
    for (int i = 0; i < NumInputs; i++) begin
      pre_i       = preamble[2*i +: 2];
      head_vec[i] = pre_i.head;
      tail_vec[i] = pre_i.tail;
    end
  end

  assign eff_req  = request & PortsEnable;
  assign cand     = eff_req & head_vec;
  assign can_send = (FlowControl == kFlowControlCreditBased) ? (credits_q != '0) : ready_in;

  noc_rr_pick #(.N(NumInputs)) u_pick (
    .req     (cand),
    .prio    (prio_q),
    .win     (win),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    credits_d = credits_q;
    err_d     = err_q;
    grant     = '0;

    unique case (state_q)
      kArbIdle: begin
        // Body/tail flits with no open packet mean upstream lost sync.
        if ((eff_req & ~head_vec) != '0) err_d = 1'b1;
        if (win_any && can_send) begin
          grant = win;
          if (tail_vec[win_idx]) begin
            prio_d = rr_next(win_idx, NumInputs);
          end else begin
            state_d = kArbLocked;
            owner_d = win_idx;
          end
        end
      end
      kArbLocked: begin
        if (eff_req[owner_q] && can_send) begin
          grant[owner_q] = 1'b1;
          if (head_vec[owner_q]) err_d = 1'b1;
          if (tail_vec[owner_q]) begin
            state_d = kArbIdle;
            prio_d  = rr_next(owner_q, NumInputs);
            owner_d = kWestPort;
          end
        end
      end
      default: state_d = kArbIdle;
    endcase

    if (!rst) grant = '0;
    out_valid = |grant;

    if (FlowControl == kFlowControlCreditBased) begin
      if (credit_in && !out_valid) begin
        if (credits_q == FullCredits) err_d = 1'b1;
        else credits_d = credits_q + OneCredit;
      end else if (out_valid && !credit_in) begin
        credits_d = credits_q - OneCredit;
      end
    end else begin
      credits_d = FullCredits;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= kArbIdle;
      prio_q    <= kWestPort;
      owner_q   <= kWestPort;
      credits_q <= FullCredits;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign locked    = (state_q == kArbLocked);
  assign owner     = owner_q;
  assign credits   = credits_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed bench for noc_output_arbiter (full mask and West/Local-only mask).
module tb_noc_output_arbiter;
  import noc::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] request, request_b;
  logic [5:0] preamble;
  logic       credit_in, credit_in_b, ready_in;

  logic [2:0] grant, grant_b;
  logic       out_valid, out_valid_b, locked, locked_b, proto_err, proto_err_b;
  logic [1:0] owner, owner_b;
  logic [2:0] credits, credits_b;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] HT = 2'b11;
  localparam logic [1:0] H  = 2'b10;
  localparam logic [1:0] B  = 2'b00;
  localparam logic [1:0] T  = 2'b01;

  logic [2:0] exp_rr [5] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [2:0] exp_b  [4] = '{3'b001, 3'b100, 3'b001, 3'b100};

  noc_output_arbiter dut (
    .clk(clk), .rst(rst), .request(request), .preamble(preamble),
    .credit_in(credit_in), .ready_in(ready_in), .grant(grant), .out_valid(out_valid),
    .locked(locked), .owner(owner), .credits(credits), .proto_err(proto_err)
  );

  noc_output_arbiter #(.PortsEnable(3'b101)) dut_b (
    .clk(clk), .rst(rst), .request(request_b), .preamble(preamble),
    .credit_in(credit_in_b), .ready_in(ready_in), .grant(grant_b), .out_valid(out_valid_b),
    .locked(locked_b), .owner(owner_b), .credits(credits_b), .proto_err(proto_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs: request, preamble {local, east, west}, credit_in; settle before checking.
  task automatic drive(input logic [2:0] req, input logic [1:0] pl, input logic [1:0] pe,
                       input logic [1:0] pw, input logic cin);
    request   = req;
    preamble  = {pl, pe, pw};
    credit_in = cin;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; request_b = '0; credit_in_b = 1'b0; ready_in = 1'b0;
    drive(3'b111, HT, HT, HT, 1'b0);
    chk("rst_grant", grant, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    tick;
    chk("rst_credits", credits, 3'd4);
    chk("rst_locked", locked, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_err", proto_err, 1'b0);
    rst = 1'b1;

    drive(3'b011, HT, HT, HT, 1'b0);
    chk("single_west", grant, 3'b001);
    chk("single_west_valid", out_valid, 1'b1);
    tick;
    chk("credits_3", credits, 3'd3);
    drive(3'b010, HT, HT, HT, 1'b0);
    chk("single_east", grant, 3'b010);
    tick;
    chk("credits_2", credits, 3'd2);

    for (int i = 0; i < 5; i++) begin
      drive(3'b111, HT, HT, HT, 1'b1);
      chk($sformatf("rr_grant_%0d", i), grant, exp_rr[i]);
      tick;
      chk($sformatf("rr_credits_%0d", i), credits, 3'd2);
    end

    drive(3'b000, HT, HT, HT, 1'b1); tick;
    drive(3'b000, HT, HT, HT, 1'b1); tick;
    chk("refill_4", credits, 3'd4);

    drive(3'b011, HT, H, H, 1'b0);
    chk("worm_head", grant, 3'b010);
    tick;
    chk("worm_locked", locked, 1'b1);
    chk("worm_owner", owner, 2'd1);
    drive(3'b011, HT, B, H, 1'b0);
    chk("worm_body", grant, 3'b010);
    tick;
    drive(3'b011, HT, T, H, 1'b0);
    chk("worm_tail", grant, 3'b010);
    tick;
    chk("worm_unlocked", locked, 1'b0);
    chk("worm_owner_west", owner, 2'd0);
    chk("worm_credits", credits, 3'd1);
    chk("worm_no_err", proto_err, 1'b0);
    drive(3'b001, HT, HT, H, 1'b0);
    chk("west_after_tail", grant, 3'b001);
    tick;
    chk("west_locked", locked, 1'b1);
    chk("west_credits_0", credits, 3'd0);

    drive(3'b001, HT, HT, B, 1'b0);
    chk("stall_grant", grant, 3'b000);
    tick;
    chk("stall_locked", locked, 1'b1);
    chk("stall_owner", owner, 2'd0);
    drive(3'b001, HT, HT, B, 1'b1);
    chk("stall_pulse_grant", grant, 3'b000);
    tick;
    chk("pulse_credits_1", credits, 3'd1);
    drive(3'b001, HT, HT, B, 1'b0);
    chk("one_flit", grant, 3'b001);
    tick;
    drive(3'b001, HT, HT, B, 1'b0);
    chk("one_flit_only", grant, 3'b000);
    tick;
    drive(3'b001, HT, HT, B, 1'b1); tick;
    drive(3'b001, HT, HT, T, 1'b0);
    chk("west_tail", grant, 3'b001);
    tick;
    chk("west_unlocked", locked, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, HT, HT, HT, 1'b1); tick;
    end
    chk("refill_again", credits, 3'd4);
    chk("err_still_0", proto_err, 1'b0);

    drive(3'b010, HT, B, HT, 1'b0);
    chk("body_idle_grant", grant, 3'b000);
    tick;
    chk("body_idle_err", proto_err, 1'b1);
    drive(3'b000, HT, HT, HT, 1'b1); tick;
    chk("sat_credits", credits, 3'd4);
    chk("sat_err", proto_err, 1'b1);
    drive(3'b000, HT, HT, HT, 1'b0); tick;
    chk("err_sticky", proto_err, 1'b1);

    drive(3'b100, H, HT, HT, 1'b0);
    chk("local_head", grant, 3'b100);
    tick;
    chk("local_locked", locked, 1'b1);
    chk("local_owner", owner, 2'd2);
    chk("local_credits", credits, 3'd3);
    rst = 1'b0;
    drive(3'b100, B, HT, HT, 1'b0);
    chk("rst_mid_grant", grant, 3'b000);
    tick;
    rst = 1'b1;
    chk("rst_mid_locked", locked, 1'b0);
    chk("rst_mid_credits", credits, 3'd4);
    chk("rst_mid_owner", owner, 2'd0);
    chk("rst_mid_err", proto_err, 1'b0);
    drive(3'b011, HT, HT, HT, 1'b0);
    chk("rst_mid_prio_west", grant, 3'b001);
    tick;

    drive(3'b000, HT, HT, HT, 1'b0);
    request_b = 3'b111;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mask_grant_%0d", i), grant_b, exp_b[i]);
      tick;
    end
    #1;
    chk("mask_no_credit", grant_b, 3'b000);
    chk("mask_credits_0", credits_b, 3'd0);
    request_b = 3'b010;
    drive(3'b000, HT, B, HT, 1'b0);
    chk("mask_east_body", grant_b, 3'b000);
    tick;
    chk("mask_no_err", proto_err_b, 1'b0);
    request_b = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
